heap_cmd_scheduler: RTL and testbench

- Upstream front-end for the heap core.
- Accepts a valid/ready command stream (push, pop, clear) and buffers it in a small command FIFO.
- Issues one single-cycle operation pulse at a time to the heap core's enable/operation/input_value inputs, honouring the core's heap_size for full/empty.
- Returns popped maxima on a valid/ready result stream.

---
 rtl/heap_cmd_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_heap_cmd_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_cmd_scheduler.sv
// Command front-end for the heap core: buffers push/pop/clear commands in a small FIFO,
// issues one heap operation at a time and returns popped maxima on a result stream.
module heap_cmd_scheduler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SIZE   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  input  logic [4:0]        heap_size,
  input  logic [DATA_W-1:0] heap_root,
  output logic              hp_enable,
  output logic [4:0]        hp_operation,
  output logic [DATA_W-1:0] hp_value,
  output logic              busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [5:0]       MAX_C   = 6'(MAX_SIZE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_POP   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [4:0] HP_INIT = 5'd0;
  localparam logic [4:0] HP_PUSH = 5'd1;
  localparam logic [4:0] HP_POP  = 5'd2;

  logic [1:0]        fifo_op_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        cmd_op_q, cmd_op_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [5:0]        mirror_q, mirror_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              hp_enable_q, hp_enable_d;
  logic [4:0]        hp_operation_q, hp_operation_d;
  logic [DATA_W-1:0] hp_value_q, hp_value_d;
  logic              busy_q, busy_d;

  logic wr_en_s, rd_en_s, heap_full_s, heap_empty_s;

  // The 5-bit heap_size reads 0 at capacity, so the mirror decides both full and "really empty".
  assign heap_full_s  = (mirror_q >= MAX_C);
  assign heap_empty_s = (heap_size == 5'd0) && (mirror_q != MAX_C);

  // Next-state logic for the FIFO pointers, the scheduler FSM and all registered outputs.
  always_comb begin
    wr_en_s        = cmd_valid && cmd_ready_q;
    rd_en_s        = (state_q == ST_IDLE) && (count_q != CNT_W'(0));
    wr_ptr_d       = wr_en_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d       = rd_en_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    state_d        = state_q;
    cmd_op_d       = cmd_op_q;
    cmd_data_d     = cmd_data_q;
    mirror_d       = mirror_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_err_d      = res_err_q;
    hp_enable_d    = 1'b0;
    hp_operation_d = hp_operation_q;
    hp_value_d     = hp_value_q;

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (rd_en_s) begin
          cmd_op_d   = fifo_op_q[rd_ptr_q];
          cmd_data_d = fifo_data_q[rd_ptr_q];
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        case (cmd_op_q)
          OP_PUSH: begin
            if (heap_full_s) begin
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
              res_data_d  = {DATA_W{1'b0}};
              state_d     = ST_RESULT;
            end else begin
              hp_enable_d    = 1'b1;
              hp_operation_d = HP_PUSH;
              hp_value_d     = cmd_data_q;
              mirror_d       = mirror_q + 6'd1;
              state_d        = ST_SETTLE;
            end
          end
          OP_POP: begin
            if (heap_empty_s) begin
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
              res_data_d  = {DATA_W{1'b0}};
              state_d     = ST_RESULT;
            end else begin
              res_data_d     = heap_root;
              res_err_d      = 1'b0;
              hp_enable_d    = 1'b1;
              hp_operation_d = HP_POP;
              mirror_d       = (mirror_q != 6'd0) ? (mirror_q - 6'd1) : mirror_q;
              state_d        = ST_SETTLE;
            end
          end
          OP_CLEAR: begin
            hp_enable_d    = 1'b1;
            hp_operation_d = HP_INIT;
            mirror_d       = 6'd0;
            state_d        = ST_SETTLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_SETTLE: begin
        if (cmd_op_q == OP_POP) begin
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (count_d != DEPTH_C);
    busy_d      = (state_d != ST_IDLE) || (count_d != CNT_W'(0));
  end

  // FIFO storage; entries are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fifo_op_q[wr_ptr_q]   <= cmd_op;
      fifo_data_q[wr_ptr_q] <= cmd_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      state_q        <= ST_IDLE;
      cmd_op_q       <= 2'd0;
      cmd_data_q     <= {DATA_W{1'b0}};
      mirror_q       <= 6'd0;
      cmd_ready_q    <= 1'b1;
      res_valid_q    <= 1'b0;
      res_data_q     <= {DATA_W{1'b0}};
      res_err_q      <= 1'b0;
      hp_enable_q    <= 1'b0;
      hp_operation_q <= 5'd0;
      hp_value_q     <= {DATA_W{1'b0}};
      busy_q         <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      cmd_op_q       <= cmd_op_d;
      cmd_data_q     <= cmd_data_d;
      mirror_q       <= mirror_d;
      cmd_ready_q    <= cmd_ready_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_err_q      <= res_err_d;
      hp_enable_q    <= hp_enable_d;
      hp_operation_q <= hp_operation_d;
      hp_value_q     <= hp_value_d;
      busy_q         <= busy_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_err      = res_err_q;
  assign hp_enable    = hp_enable_q;
  assign hp_operation = hp_operation_q;
  assign hp_value     = hp_value_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_heap_cmd_scheduler.sv
// Directed bench for heap_cmd_scheduler with a behavioural heap core attached.
module tb_heap_cmd_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        core_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic [4:0]  heap_size;
  logic [31:0] heap_root;
  logic        hp_enable;
  logic [4:0]  hp_operation;
  logic [31:0] hp_value;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  heap_cmd_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .MAX_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .heap_size(heap_size), .heap_root(heap_root),
    .hp_enable(hp_enable), .hp_operation(hp_operation), .hp_value(hp_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural heap core: unordered store, root is the current maximum.
  logic [31:0] hv [64];
  int          hn;
  int          mx_idx;
  logic [31:0] mx_val;

  always_comb begin
    mx_idx = 0;
    mx_val = 32'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < hn && hv[i] > mx_val) begin
        mx_val = hv[i];
        mx_idx = i;
      end
    end
  end

  assign heap_size = hn[4:0];
  assign heap_root = (hn > 0) ? mx_val : 32'd0;

  always_ff @(posedge clk) begin
    if (core_rst) begin
      hn <= 0;
    end else if (hp_enable) begin
      case (hp_operation)
        5'd1: begin hv[hn] <= hp_value; hn <= hn + 1; end
        5'd2: if (hn > 0) begin hv[mx_idx] <= hv[hn-1]; hn <= hn - 1; end
        5'd0: hn <= 0;
        default: ;
      endcase
    end
  end

  // Logs of issued pulses and accepted results, stamped with the edge number.
  int          cyc = 0;
  int          rv_cnt = 0;
  logic [4:0]  p_op  [$];
  logic [31:0] p_val [$];
  int          p_cyc [$];
  logic [31:0] r_data[$];
  logic        r_err [$];
  int          r_cyc [$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rv_cnt <= rv_cnt + (res_valid ? 1 : 0);
    if (hp_enable) begin
      p_op.push_back(hp_operation);
      p_val.push_back(hp_value);
      p_cyc.push_back(cyc + 1);
    end
    if (res_valid && res_ready) begin
      r_data.push_back(res_data);
      r_err.push_back(res_err);
      r_cyc.push_back(cyc + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d);
    int g = 0;
    while (cmd_ready !== 1'b1 && g < 200) begin tick(); g++; end
    if (g >= 200) chk("send_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(busy === 1'b0 && res_valid === 1'b0) && g < 400) begin tick(); g++; end
    if (g >= 400) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, base, rb;
    reset = 1'b1; core_rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0; res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_hp_enable", 64'(hp_enable), 64'd0);
    chk("rst_hp_op", 64'(hp_operation), 64'd0);
    chk("rst_hp_value", 64'(hp_value), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0; core_rst = 1'b0;
    tick();

    // Three back-to-back pushes: one pulse every 3 cycles, first 3 edges after the write.
    send(2'd0, 32'd5); w = cyc;
    send(2'd0, 32'd17);
    send(2'd0, 32'd3);
    wait_idle();
    chk("busy_fall_cycle", 64'(cyc), 64'(w + 9));
    chk("push_count", 64'(p_op.size()), 64'd3);
    chk("push0_op", 64'(p_op[0]), 64'd1);
    chk("push0_val", 64'(p_val[0]), 64'd5);
    chk("push1_val", 64'(p_val[1]), 64'd17);
    chk("push2_op", 64'(p_op[2]), 64'd1);
    chk("push2_val", 64'(p_val[2]), 64'd3);
    chk("push0_latency", 64'(p_cyc[0]), 64'(w + 3));
    chk("push1_spacing", 64'(p_cyc[1]), 64'(w + 6));
    chk("push2_spacing", 64'(p_cyc[2]), 64'(w + 9));

    // Three pops with the consumer always ready.
    rb = rv_cnt;
    send(2'd1, 32'd0); send(2'd1, 32'd0); send(2'd1, 32'd0);
    wait_idle();
    chk("pop_res_count", 64'(r_data.size()), 64'd3);
    chk("pop0_data", 64'(r_data[0]), 64'd17);
    chk("pop1_data", 64'(r_data[1]), 64'd5);
    chk("pop2_data", 64'(r_data[2]), 64'd3);
    chk("pop0_err", 64'(r_err[0]), 64'd0);
    chk("pop2_err", 64'(r_err[2]), 64'd0);
    chk("pop_spacing", 64'(r_cyc[1] - r_cyc[0]), 64'd4);
    chk("res_valid_cycles", 64'(rv_cnt - rb), 64'd3);
    chk("pop_pulse_op", 64'(p_op[5]), 64'd2);

    // Pop on empty heap held by back-pressure while four pushes fill the FIFO.
    res_ready = 1'b0;
    base = p_op.size();
    send(2'd1, 32'd0);
    tick(); tick();
    chk("empty_res_valid", 64'(res_valid), 64'd1);
    chk("empty_res_err", 64'(res_err), 64'd1);
    chk("empty_res_data", 64'(res_data), 64'd0);
    send(2'd0, 32'd7); send(2'd0, 32'd8); send(2'd0, 32'd9);
    chk("ready_at_3", 64'(cmd_ready), 64'd1);
    send(2'd0, 32'd10);
    chk("ready_at_4", 64'(cmd_ready), 64'd0);
    chk("no_pulse_held", 64'(p_op.size()), 64'(base));
    res_ready = 1'b1;
    wait_idle();
    chk("empty_logged_err", 64'(r_err[3]), 64'd1);
    chk("after_fill_pulses", 64'(p_op.size()), 64'(base + 4));
    chk("after_fill_last", 64'(p_val[base + 3]), 64'd10);

    // Clear, fill to capacity, then two rejected pushes.
    send(2'd2, 32'd0);
    for (int i = 1; i <= 32; i++) send(2'd0, 32'(i));
    send(2'd0, 32'hDEAD);
    wait_idle();
    chk("clear_op", 64'(p_op[base + 4]), 64'd0);
    chk("full_pulses", 64'(p_op.size()), 64'(base + 4 + 33));
    chk("full_last_val", 64'(p_val[p_val.size() - 1]), 64'd32);
    chk("full_res_err", 64'(r_err[r_err.size() - 1]), 64'd1);
    chk("full_res_data", 64'(r_data[r_data.size() - 1]), 64'd0);
    base = p_op.size();
    send(2'd0, 32'hBEEF);
    wait_idle();
    chk("still_full_err", 64'(r_err[r_err.size() - 1]), 64'd1);
    chk("still_full_nopulse", 64'(p_op.size()), 64'(base));

    // Held pop result must stay stable and block a queued push.
    send(2'd2, 32'd0); send(2'd0, 32'd40); send(2'd0, 32'd60);
    wait_idle();
    base = p_op.size();
    res_ready = 1'b0;
    send(2'd1, 32'd0);
    send(2'd0, 32'd70);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("held_valid", 64'(res_valid), 64'd1);
      chk("held_data", 64'(res_data), 64'd60);
      tick();
    end
    chk("held_no_push", 64'(p_op.size()), 64'(base + 1));
    res_ready = 1'b1;
    wait_idle();
    chk("held_res_err", 64'(r_err[r_err.size() - 1]), 64'd0);
    chk("released_push_op", 64'(p_op[base + 1]), 64'd1);
    chk("released_push_val", 64'(p_val[base + 1]), 64'd70);

    // Reset while the second of five queued pushes is settling.
    send(2'd0, 32'd101); send(2'd0, 32'd102); send(2'd0, 32'd103);
    send(2'd0, 32'd104); send(2'd0, 32'd105);
    tick();
    chk("pre_rst_enable", 64'(hp_enable), 64'd1);
    chk("pre_rst_value", 64'(hp_value), 64'd102);
    reset = 1'b1;
    #1;
    chk("mid_rst_enable", 64'(hp_enable), 64'd0);
    chk("mid_rst_value", 64'(hp_value), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    tick(); tick();
    reset = 1'b0;
    base = p_op.size();
    repeat (10) tick();
    chk("post_rst_no_pulse", 64'(p_op.size()), 64'(base));
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
